// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a 4-bit sum/carry slice.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output overflow_o.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state, next_state;
  logic [WIDTH-1:0]    a_sh, b_sh;
  logic [WIDTH-5:0]    result_part;
  logic                carry_r;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                load, step;
  logic [4:0]          slice;
  logic [WIDTH-1:0]    shifted;

  assign slice   = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_r};
  assign shifted = {slice[3:0], result_part};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          load       = 1'b1;
          next_state = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The published result lives in its own register so the shifting
  // accumulator never exposes a partially assembled sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh        <= '0;
      b_sh        <= '0;
      result_part <= '0;
      carry_r     <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (load) begin
      a_sh        <= a_i;
      b_sh        <= b_i;
      carry_r     <= carry_i;
      result_part <= '0;
      cnt         <= '0;
    end else if (step) begin
      a_sh        <= a_sh >> 4;
      b_sh        <= b_sh >> 4;
      result_part <= shifted[WIDTH-1:4];
      carry_r     <= slice[4];
      cnt         <= cnt + 1'b1;
      if (cnt == LAST) begin
        sum_q  <= shifted;
        cout_q <= slice[4];
      end
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = cout_q;

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the top bit of the last nibble's sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     ovf_q <= 1'b0;
    else if (step && cnt == LAST)  ovf_q <= (a_sh[3] ^ b_sh[3] ^ slice[3]) ^ slice[4];
  end

  assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=32) against a plain-arithmetic reference.
module tb_nibble_serial_adder;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             carry_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic             overflow_o;
`endif

  int testCount = 0;
  int failCount = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow_o (overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation end to end; garbage operands are driven during ADD,
  // optionally with a stray valid_i pulse, and the result is held for `hold` cycles.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input int hold, input bit inject);
    logic [WIDTH:0] ref_full;
    int wait_cnt;
    int cycles;
    ref_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};

    @(negedge clk_i);
    wait_cnt = 0;
    while (!ready_o && wait_cnt < 50) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    if (!ready_o) checkOutput("ready_timeout", 64'(ready_o), 64'd1);

    a_i = a; b_i = b; carry_i = c; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; carry_i = 1'($urandom);
    checkOutput("ready_busy", 64'(ready_o), 64'd0);

    cycles = 1;
    while (!valid_o && cycles < 50) begin
      valid_i = (inject && cycles == 3);
      @(posedge clk_i);
      #1;
      cycles++;
    end
    valid_i = 1'b0;
    checkOutput("latency", 64'(cycles), 64'd9);
    checkOutput("sum", 64'(sum_o), 64'(ref_full[WIDTH-1:0]));
    checkOutput("carry", 64'(carry_o), 64'(ref_full[WIDTH]));
    checkOutput("ready_done", 64'(ready_o), 64'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    checkOutput("overflow", 64'(overflow_o),
                64'((a[WIDTH-1] == b[WIDTH-1]) && (ref_full[WIDTH-1] != a[WIDTH-1])));
`endif

    for (int i = 0; i < hold; i++) begin
      a_i = $urandom; valid_i = 1'($urandom);
      @(posedge clk_i);
      #1;
      checkOutput("hold_valid", 64'(valid_o), 64'd1);
      checkOutput("hold_sum", 64'(sum_o), 64'(ref_full[WIDTH-1:0]));
      checkOutput("hold_ready", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;

    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    checkOutput("drop_valid", 64'(valid_o), 64'd0);
    checkOutput("idle_ready", 64'(ready_o), 64'd1);
    checkOutput("kept_sum", 64'(sum_o), 64'(ref_full[WIDTH-1:0]));
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_sum", 64'(sum_o), 64'd0);
    checkOutput("rst_carry", 64'(carry_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, 1'b1);

    // Asynchronous reset in the middle of ADD cycle 4.
    @(negedge clk_i);
    a_i = 32'hAAAA_AAAA; b_i = 32'h5555_5555; carry_i = 1'b1; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_ready", 64'(ready_o), 64'd1);
    checkOutput("midrst_valid", 64'(valid_o), 64'd0);
    checkOutput("midrst_sum", 64'(sum_o), 64'd0);
    checkOutput("midrst_carry", 64'(carry_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0);

    for (int k = 0; k < 512; k++) begin
      applyStimulus({28'd0, 4'(k)}, {28'd0, 4'(k >> 4)}, 1'(k >> 8), 0, 1'b0);
    end

    for (int r = 0; r < 40; r++) begin
      applyStimulus($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
